// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
//   SEG_OFF / AN_OFF : idle pin levels (active-low bus, everything dark)
//   scan_state_e     : per-slot FSM states
//   disp_cfg_t       : one complete display setting (shadow and active copies)
//   hex2seg          : nibble -> lit-high segments {g,f,e,d,c,b,a}
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic [0:0] {
    BLANK,
    SHOW
  } scan_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        raw_mode;
    logic [27:0] raw;
  } disp_cfg_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h00;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Segment source select for the digit currently being scanned.
//   nibble_i   : hex nibble of the current digit
//   raw_i      : raw lit-high segments {g..a} of the current digit
//   raw_mode_i : 1 = pass raw_i, 0 = hex decode of nibble_i
//   seg_o      : lit-high segments {g..a}
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic [6:0] raw_i,
  input  logic       raw_mode_i,
  output logic [6:0] seg_o
);

  assign seg_o = raw_mode_i ? raw_i : hex2seg(nibble_i);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed driver for a shared 4-digit seven-segment bus.
// Each digit owns one slot of SLOT cycles: BLANK_CYCLES with all anodes off (ghosting guard),
// then the digit is driven. New settings land in a shadow copy and are only committed to the
// active copy on the last cycle of digit 3, so a frame never mixes old and new data.
//   clk, rst_n     : clock, synchronous active-low reset
//   load           : capture value_i/dp_i/en_i/raw_i/raw_mode into the shadow copy
//   value_i, dp_i  : hex nibbles (digit 0 in [3:0]) and decimal points, 1 = lit
//   en_i           : per-digit enable, 0 = dark for the whole slot
//   raw_mode,raw_i : raw segment mode and 7 lit-high bits {g..a} per digit
//   pending        : shadow holds data not yet committed
//   frame          : high on each commit cycle
//   seg, dp, an    : registered active-low pin outputs
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 4_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  en_i,
  input  logic        raw_mode,
  input  logic [27:0] raw_i,
  output logic        pending,
  output logic        frame,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned SLOT   = CLK_HZ / SCAN_HZ;
  localparam int unsigned TICK_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SLOT - 1);
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_CYCLES - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        digit_q, digit_d;
  scan_state_e       state_q, state_d;
  logic              pending_q, pending_d;
  disp_cfg_t         shadow_q, shadow_d;
  disp_cfg_t         active_q, active_d;
  disp_cfg_t         cfg_in;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;

  logic       slot_end;
  logic       commit;
  logic       show;
  logic [3:0] cur_nibble;
  logic [6:0] cur_raw;
  logic [6:0] cur_lit;

  assign cfg_in = '{value: value_i, dp: dp_i, en: en_i, raw_mode: raw_mode, raw: raw_i};

  assign slot_end = (tick_q == TICK_LAST);
  assign commit   = slot_end && (digit_q == 2'd3);

  // Counters and slot FSM
  always_comb begin
    tick_d  = slot_end ? '0 : tick_q + 1'b1;
    digit_d = slot_end ? digit_q + 2'd1 : digit_q;
    state_d = state_q;
    unique case (state_q)
      BLANK: if (tick_q == BLANK_LAST) state_d = SHOW;
      SHOW:  if (slot_end) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Shadow/active handling; a load on the commit cycle bypasses straight to active.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d  = cfg_in;
      pending_d = 1'b1;
    end
    if (commit) begin
      if (load) begin
        active_d  = cfg_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  assign cur_nibble = active_q.value[{digit_q, 2'b00} +: 4];
  assign cur_raw    = active_q.raw[7 * digit_q +: 7];

  sevenseg_decode u_decode (
    .nibble_i   (cur_nibble),
    .raw_i      (cur_raw),
    .raw_mode_i (active_q.raw_mode),
    .seg_o      (cur_lit)
  );

  // Pin next-state; a disabled digit keeps the bus dark but still uses its slot.
  always_comb begin
    show = (state_q == SHOW) && active_q.en[digit_q];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (show) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = ~cur_lit;
      dp_d  = ~active_q.dp[digit_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q    <= '0;
      digit_q   <= 2'd0;
      state_q   <= BLANK;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      an_q      <= AN_OFF;
    end else begin
      tick_q    <= tick_d;
      digit_q   <= digit_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign pending = pending_q;
  assign frame   = commit;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with SLOT=10, BLANK_CYCLES=2 (frame = 40 cycles).
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [3:0]  en_i;
  logic        raw_mode;
  logic [27:0] raw_i;
  logic        pending;
  logic        frame;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [11:0] OFF = 12'hFFF;  // {an=F, seg=7F, dp=1}

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .CLK_HZ       (400),
    .SCAN_HZ      (40),
    .BLANK_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value_i  (value_i),
    .dp_i     (dp_i),
    .en_i     (en_i),
    .raw_mode (raw_mode),
    .raw_i    (raw_i),
    .pending  (pending),
    .frame    (frame),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input logic [3:0] a, input logic [6:0] s, input logic d);
    return {a, s, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                         input logic rm, input logic [27:0] r);
    value_i  = v;
    dp_i     = d;
    en_i     = e;
    raw_mode = rm;
    raw_i    = r;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Advance until the commit cycle is visible (frame high), bounded.
  task automatic wait_frame();
    int n;
    n = 0;
    while (frame !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    if (frame !== 1'b1) check("frame_timeout", {31'b0, frame}, 32'd1);
  endtask

  // Entered one cycle after a commit edge. Pins lag the FSM by one cycle, so at step s the
  // pins show slot-tick (s-2)%10 of digit (s-2)/10; ticks 0..1 are the blanking guard.
  // exp_all = {d3, d2, d1, d0} packed pin values while a digit is shown.
  task automatic frame_body(input string tag, input logic [47:0] exp_all);
    int t;
    int d;
    logic [11:0] exp;
    for (int s = 2; s <= 40; s++) begin
      step();
      t = (s - 2) % 10;
      d = (s - 2) / 10;
      exp = (t >= 2) ? exp_all[d*12 +: 12] : OFF;
      check(tag, {20'b0, an, seg, dp}, {20'b0, exp});
    end
    check({tag, "_period"}, {31'b0, frame}, 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [47:0] exp_all);
    step();
    frame_body(tag, exp_all);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value_i  = '0;
    dp_i     = '0;
    en_i     = '0;
    raw_mode = 1'b0;
    raw_i    = '0;

    // 1: reset state, then a dark frame
    step(); step(); step();
    check("rst_seg", {25'b0, seg}, 32'h7F);
    check("rst_dp", {31'b0, dp}, 32'd1);
    check("rst_an", {28'b0, an}, 32'hF);
    check("rst_pending", {31'b0, pending}, 32'd0);
    check("rst_frame", {31'b0, frame}, 32'd0);
    rst_n = 1'b1;
    wait_frame();
    run_frame("t1_dark", {OFF, OFF, OFF, OFF});

    // 2: 1234 on all digits
    step();
    do_load(16'h1234, 4'h0, 4'hF, 1'b0, 28'h0);
    check("t2_pend_set", {31'b0, pending}, 32'd1);
    wait_frame();
    check("t2_pend_hold", {31'b0, pending}, 32'd1);
    run_frame("t2", {pk(4'h7, 7'h79, 1'b1), pk(4'hB, 7'h24, 1'b1),
                     pk(4'hD, 7'h30, 1'b1), pk(4'hE, 7'h19, 1'b1)});
    check("t2_pend_clr", {31'b0, pending}, 32'd0);

    // 3: digits 1 and 3 disabled
    step();
    do_load(16'h8888, 4'h0, 4'b0101, 1'b0, 28'h0);
    wait_frame();
    run_frame("t3", {OFF, pk(4'hB, 7'h00, 1'b1), OFF, pk(4'hE, 7'h00, 1'b1)});

    // 4: back-to-back loads, last one wins
    step();
    do_load(16'hAAAA, 4'h0, 4'hF, 1'b0, 28'h0);
    do_load(16'hFFFF, 4'h0, 4'hF, 1'b0, 28'h0);
    wait_frame();
    run_frame("t4", {pk(4'h7, 7'h0E, 1'b1), pk(4'hB, 7'h0E, 1'b1),
                     pk(4'hD, 7'h0E, 1'b1), pk(4'hE, 7'h0E, 1'b1)});

    // 5: load on the commit cycle bypasses to active
    check("t5_frame", {31'b0, frame}, 32'd1);
    do_load(16'h0000, 4'h0, 4'hF, 1'b0, 28'h0);
    check("t5_pend", {31'b0, pending}, 32'd0);
    frame_body("t5", {pk(4'h7, 7'h40, 1'b1), pk(4'hB, 7'h40, 1'b1),
                      pk(4'hD, 7'h40, 1'b1), pk(4'hE, 7'h40, 1'b1)});

    // 6: raw mode on digit 0 with its decimal point, then reset mid-SHOW
    step();
    do_load(16'h0000, 4'b0001, 4'b0001, 1'b1, 28'h49);
    wait_frame();
    run_frame("t6", {OFF, OFF, OFF, pk(4'hE, 7'h36, 1'b0)});
    for (int i = 0; i < 5; i++) step();
    check("t6_pre_rst", {20'b0, an, seg, dp}, {20'b0, pk(4'hE, 7'h36, 1'b0)});
    rst_n = 1'b0;
    step();
    check("t6_rst_an", {28'b0, an}, 32'hF);
    check("t6_rst_seg", {25'b0, seg}, 32'h7F);
    check("t6_rst_dp", {31'b0, dp}, 32'd1);
    check("t6_rst_frame", {31'b0, frame}, 32'd0);
    rst_n = 1'b1;
    wait_frame();
    run_frame("t6_post_rst", {OFF, OFF, OFF, OFF});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
